// File: rtl/input_mar_loader_if.sv
// Operator, bus and RAM-side signals of the input/MAR loader.
// The DUT takes the slave modport; the panel/bus side drives the master modport.
interface input_mar_loader_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          prog;
   logic          lm;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] in_data;
   logic          in_set_addr;
   logic          in_valid;
   logic          in_ack;
   logic [AW-1:0] mar_out;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic          busy;
   logic          wrapped;

   modport master (
      output prog, lm, bus_addr, in_data, in_set_addr, in_valid,
      input  in_ack, mar_out, ram_wdata, ram_we, busy, wrapped
   );

   modport slave (
      input  prog, lm, bus_addr, in_data, in_set_addr, in_valid,
      output in_ack, mar_out, ram_wdata, ram_we, busy, wrapped
   );
endinterface

// File: rtl/input_mar_loader.sv
// Memory address register with run-mode bus load and a front-panel loader
// (address entry / deposit with auto-increment) over a valid/ack handshake.
module input_mar_loader #(
   parameter int            AW         = 8,
   parameter int            DW         = 8,
   parameter logic [AW-1:0] START_ADDR = '0
) (
   input logic                clk,
   input logic                clr_n,
   input_mar_loader_if.slave  bus
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WRITE   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   logic [1:0]    state;
   logic [AW-1:0] mar;
   logic [DW-1:0] wdata;
   logic          we;
   logic          ack;
   logic          wrap;
   logic [AW-1:0] in_addr;

   // Switch word resized to the MAR width.
   generate
      if (AW > DW) begin : g_ext
         assign in_addr = {{(AW-DW){1'b0}}, bus.in_data};
      end else begin : g_trunc
         assign in_addr = bus.in_data[AW-1:0];
      end
   endgenerate

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= S_IDLE;
         mar   <= START_ADDR;
         wdata <= '0;
         we    <= 1'b0;
         ack   <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         we  <= 1'b0;
         ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!bus.prog) begin
                  if (bus.lm) mar <= bus.bus_addr;
               end else if (bus.in_valid) begin
                  if (bus.in_set_addr) begin
                     mar   <= in_addr;
                     ack   <= 1'b1;
                     wrap  <= 1'b0;
                     state <= S_RELEASE;
                  end else begin
                     wdata <= bus.in_data;
                     we    <= 1'b1;
                     state <= S_WRITE;
                  end
               end
            end
            // Deposit completes regardless of prog so a mode change cannot abort it.
            S_WRITE: begin
               mar   <= mar + 1'b1;
               ack   <= 1'b1;
               if (&mar) wrap <= 1'b1;
               state <= S_RELEASE;
            end
            S_RELEASE: begin
               if (!bus.in_valid) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.mar_out   = mar;
   assign bus.ram_wdata = wdata;
   assign bus.ram_we    = we;
   assign bus.in_ack    = ack;
   assign bus.busy      = (state != S_IDLE);
   assign bus.wrapped   = wrap;
endmodule

// File: tb/tb_input_mar_loader.sv
// Directed bench for input_mar_loader: vector table plus mode-change and reset-mid-write sequences.
module tb_input_mar_loader;
   logic clk;
   logic clr_n;
   int   total;
   int   bad;

   input_mar_loader_if #(.AW(8), .DW(8)) bus_if ();

   input_mar_loader #(.AW(8), .DW(8), .START_ADDR(8'h00)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       prog;
      logic       lm;
      logic [7:0] bus_addr;
      logic [7:0] in_data;
      logic       set_addr;
      logic       valid;
      logic [7:0] e_mar;
      logic       e_ack;
      logic       e_we;
      logic       e_busy;
      logic [7:0] e_wdata;
      logic       e_wrapped;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic p, input logic l, input logic [7:0] ba, input logic [7:0] d,
                      input logic s, input logic v, input logic [7:0] m, input logic a,
                      input logic w, input logic b, input logic [7:0] wd, input logic wr);
      vec_t t;
      t.prog = p; t.lm = l; t.bus_addr = ba; t.in_data = d; t.set_addr = s; t.valid = v;
      t.e_mar = m; t.e_ack = a; t.e_we = w; t.e_busy = b; t.e_wdata = wd; t.e_wrapped = wr;
      vecs.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic p, input logic l, input logic [7:0] ba,
                        input logic [7:0] d, input logic s, input logic v);
      bus_if.prog = p; bus_if.lm = l; bus_if.bus_addr = ba;
      bus_if.in_data = d; bus_if.in_set_addr = s; bus_if.in_valid = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clr_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

      //    prog lm  bus    data   set  vld | mar    ack  we   busy wdata  wrap
      add(1'b0, 1'b1, 8'h2A, 8'h00, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      add(1'b0, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      add(1'b0, 1'b0, 8'h55, 8'h10, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++)
         add(1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hA1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hA1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hA1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hB2, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hB2, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hB2, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 8'hB2, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b0, 8'h13, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
      add(1'b1, 1'b1, 8'h99, 8'h00, 1'b0, 1'b0, 8'h13, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'h77, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'h77, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
      add(1'b1, 1'b0, 8'h00, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
      add(1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
      add(1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0);

      #12;
      chk("rst_mar",     bus_if.mar_out,   8'h00);
      chk("rst_wdata",   bus_if.ram_wdata, 8'h00);
      chk("rst_we",      bus_if.ram_we,    1'b0);
      chk("rst_ack",     bus_if.in_ack,    1'b0);
      chk("rst_busy",    bus_if.busy,      1'b0);
      chk("rst_wrapped", bus_if.wrapped,   1'b0);
      clr_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].prog, vecs[i].lm, vecs[i].bus_addr, vecs[i].in_data,
               vecs[i].set_addr, vecs[i].valid);
         tick();
         chk($sformatf("v%0d_mar", i),     bus_if.mar_out,   vecs[i].e_mar);
         chk($sformatf("v%0d_ack", i),     bus_if.in_ack,    vecs[i].e_ack);
         chk($sformatf("v%0d_we", i),      bus_if.ram_we,    vecs[i].e_we);
         chk($sformatf("v%0d_busy", i),    bus_if.busy,      vecs[i].e_busy);
         chk($sformatf("v%0d_wdata", i),   bus_if.ram_wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_wrapped", i), bus_if.wrapped,   vecs[i].e_wrapped);
      end

      // Mode change during WRITE: deposit at 0x20 completes, lm waits for IDLE.
      drive(1'b1, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1);
      tick();
      chk("mc_we",    bus_if.ram_we,    1'b1);
      chk("mc_addr",  bus_if.mar_out,   8'h20);
      chk("mc_wdata", bus_if.ram_wdata, 8'h5A);
      drive(1'b0, 1'b1, 8'h40, 8'h5A, 1'b0, 1'b1);
      tick();
      chk("mc_inc",   bus_if.mar_out,   8'h21);
      chk("mc_ack",   bus_if.in_ack,    1'b1);
      chk("mc_we_lo", bus_if.ram_we,    1'b0);
      tick();
      chk("mc_hold",  bus_if.mar_out,   8'h21);
      chk("mc_busy",  bus_if.busy,      1'b1);
      bus_if.in_valid = 1'b0;
      tick();
      chk("mc_idle",  bus_if.busy,      1'b0);
      chk("mc_noload", bus_if.mar_out,  8'h21);
      tick();
      chk("mc_load",  bus_if.mar_out,   8'h40);

      // Reset asserted inside the WRITE cycle.
      drive(1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 1'b1);
      tick();
      chk("rw_we_pre", bus_if.ram_we, 1'b1);
      #2;
      clr_n = 1'b0;
      #1;
      chk("rw_we",   bus_if.ram_we,    1'b0);
      chk("rw_ack",  bus_if.in_ack,    1'b0);
      chk("rw_busy", bus_if.busy,      1'b0);
      chk("rw_mar",  bus_if.mar_out,   8'h00);
      chk("rw_wd",   bus_if.ram_wdata, 8'h00);
      bus_if.in_valid = 1'b0;
      tick();
      clr_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rw_post%0d_ack", i), bus_if.in_ack,  1'b0);
         chk($sformatf("rw_post%0d_we", i),  bus_if.ram_we,  1'b0);
         chk($sformatf("rw_post%0d_mar", i), bus_if.mar_out, 8'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/input_mar_loader.md
Name: input_mar_loader

Overview:
- Parametrised successor to the SAP-2 mini input/MAR block. Holds the memory address register (MAR) that drives the RAM address.
- Run mode (prog=0): MAR loads from the bus when lm is high.
- Program mode (prog=1): a front-panel loader with a valid/ack handshake. It sets the MAR from switch input, deposits data words into RAM through a one-cycle write strobe, and auto-increments the MAR after each deposit.
- Sits between the input switches/bus and the RAM.

Parameters:
- AW, 8, MAR/address width in bits.
- DW, 8, data/switch input width in bits.
- START_ADDR, 0, MAR value after reset (AW bits).

Ports:
- clk  in  1  system clock, rising-edge.
- clr_n  in  1  asynchronous active-low reset.
- prog  in  1  mode select: 1 = program/loader, 0 = run.
- lm  in  1  run-mode MAR load enable.
- bus_addr  in  AW  run-mode address source.
- in_data  in  DW  switch input: address or data word.
- in_set_addr  in  1  qualifies in_data: 1 = address entry, 0 = data deposit.
- in_valid  in  1  operator request. Held until in_ack is seen, then dropped.
- in_ack  out  1  one-cycle completion pulse.
- mar_out  out  AW  current MAR, which is the RAM address.
- ram_wdata  out  DW  data to RAM, registered.
- ram_we  out  1  one-cycle RAM write strobe.
- busy  out  1  high whenever state != IDLE.
- wrapped  out  1  sticky: set when a post-deposit increment wraps the MAR from all-ones to 0.

Behaviour:
- Reset (clr_n=0, async):
  - mar_out=START_ADDR.
  - ram_wdata=0, ram_we=0, in_ack=0, wrapped=0.
  - state=IDLE.
  - Reset mid-write aborts immediately; no write strobe is issued after reset.
- States: IDLE, WRITE, RELEASE. All updates occur on the rising clk edge.
- IDLE, prog=0:
  - lm=1 gives mar_out<=bus_addr at that edge; otherwise MAR holds.
  - in_valid is ignored and in_ack stays 0.
- IDLE, prog=1:
  - lm and bus_addr are ignored.
  - in_valid=1 with in_set_addr=1:
    - mar_out<=in_data, zero-extended if AW>DW, truncated to the low AW bits if AW<DW.
    - in_ack<=1 and state<=RELEASE.
    - wrapped is cleared.
  - in_valid=1 with in_set_addr=0: ram_wdata<=in_data (zero-extend/truncate to DW), state<=WRITE.
- WRITE: lasts exactly one cycle. Entered regardless of prog, so a mode change never aborts a deposit.
  - ram_we=1 (registered: asserted for the whole WRITE cycle). mar_out holds the write address.
  - At the end of the cycle: mar_out<=mar_out+1 modulo 2^AW; in_ack<=1; state<=RELEASE.
  - If mar_out was all-ones, wrapped<=1.
- RELEASE:
  - in_ack is high only in the first cycle after entry, then 0.
  - State stays in RELEASE while in_valid=1 and returns to IDLE on the first edge with in_valid=0, regardless of prog.
  - A held in_valid therefore never triggers a second transfer.
- Latency:
  - Address entry: in_ack 1 cycle after the accepting edge.
  - Deposit: ram_we 1 cycle after acceptance, in_ack and the incremented MAR 2 cycles after acceptance.
  - Minimum repeat: one in_valid-low cycle between transfers.
- Simultaneous events:
  - prog toggled while busy: takes effect only on return to IDLE.
  - lm asserted while busy or in program mode: ignored.
- ram_wdata holds its last deposited value outside WRITE.

Test Plan:
- Reset/run load: assert clr_n=0 mid-cycle with START_ADDR=0 -> mar_out=0 asynchronously. Release reset, prog=0, lm=1, bus_addr=0x2A -> mar_out=0x2A after 1 edge. lm=0, bus_addr=0x55 -> mar_out stays 0x2A.
- Address entry: prog=1, in_set_addr=1, in_data=0x10, in_valid=1 -> mar_out=0x10 and in_ack pulses 1 cycle. Holding in_valid high for 5 cycles gives no further ack; busy stays 1 until in_valid=0, then IDLE.
- Deposit sequence: from MAR=0x10, deposit 0xA1, 0xB2, 0xC3 with full handshakes -> exactly 3 ram_we pulses at addresses 0x10/0x11/0x12 with ram_wdata 0xA1/0xB2/0xC3. Final mar_out=0x13.
- Wrap: set MAR=0xFF, deposit 0x77 -> write at 0xFF, mar_out=0x00, wrapped=1. A subsequent address entry clears wrapped.
- Mode change mid-op: accept a deposit, drop prog to 0 and assert lm=1 with bus_addr=0x40 during WRITE -> write completes at the original address and the MAR increments. Once in_valid drops and the block reaches IDLE, lm then loads 0x40.
- Reset mid-write: assert clr_n=0 during the WRITE cycle -> ram_we, in_ack and busy drop immediately, mar_out=START_ADDR. No ack after reset is released.
